// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register-file dump reader.
// The sequencer state encoding lives here so the bench and RTL agree on it.
package regfile_pkg;

    localparam int NREGS_DEF  = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_mask_prienc.sv
// Lowest-set-bit encoder over the pending register mask.
// Also flags when exactly one bit remains, which marks the final beat of a dump.
module regfile_mask_prienc
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [NREGS-1:0]  mask,
    output logic              found,
    output logic [ADDR_W-1:0] idx,
    output logic              single
);

    always_comb begin
        found = |mask;
        idx   = '0;
        // Descending scan so the lowest set bit is the final assignment.
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (mask[i]) idx = ADDR_W'(i);
        end
        single = found && ((mask & (mask - NREGS'(1))) == '0);
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Read-side sequencer that walks a masked subset of the register file in
// ascending index order and streams each value as one valid/ready beat.
//
// state | meaning
// IDLE  | waiting for start; outputs idle, beats_sent holds last count
// SCAN  | rd_addr = lowest pending index; capture rd_data into the beat
// SEND  | beat presented; held until accepted
// DONE  | one-cycle done pulse after the final beat
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic [NREGS-1:0]  reg_mask,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   beats_sent
);

    state_t              state, state_n;
    logic [NREGS-1:0]    pending, pending_n;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_q_n;
    logic [DATA_W-1:0]   out_data_n;
    logic [ADDR_W-1:0]   out_idx_n;
    logic                out_last_n;
    logic                out_valid_n;
    logic [ADDR_W:0]     beats_sent_n;

    logic                enc_found;
    logic [ADDR_W-1:0]   enc_idx;
    logic                enc_single;
    logic                handshake;

    regfile_mask_prienc #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_prienc (
        .mask   (pending),
        .found  (enc_found),
        .idx    (enc_idx),
        .single (enc_single)
    );

    assign handshake = out_valid && out_ready;
    // The port address follows the encoder only while scanning, otherwise it
    // keeps pointing at the last register read.
    assign rd_addr   = (state == ST_SCAN) ? enc_idx : rd_addr_q;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE) && !abort;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state      <= ST_IDLE;
            pending    <= '0;
            rd_addr_q  <= '0;
            out_data   <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
            beats_sent <= '0;
        end else begin
            state      <= state_n;
            pending    <= pending_n;
            rd_addr_q  <= rd_addr_q_n;
            out_data   <= out_data_n;
            out_idx    <= out_idx_n;
            out_last   <= out_last_n;
            out_valid  <= out_valid_n;
            beats_sent <= beats_sent_n;
        end
    end

    always_comb begin
        state_n      = state;
        pending_n    = pending;
        rd_addr_q_n  = rd_addr_q;
        out_data_n   = out_data;
        out_idx_n    = out_idx;
        out_last_n   = out_last;
        out_valid_n  = out_valid;
        beats_sent_n = beats_sent;

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    beats_sent_n = '0;
                    if (reg_mask != '0) begin
                        pending_n = reg_mask;
                        state_n   = ST_SCAN;
                    end else begin
                        state_n   = ST_DONE;
                    end
                end
            end
            ST_SCAN: begin
                if (enc_found) begin
                    rd_addr_q_n = enc_idx;
                    out_data_n  = rd_data;
                    out_idx_n   = enc_idx;
                    out_last_n  = enc_single;
                    out_valid_n = 1'b1;
                    state_n     = ST_SEND;
                end else begin
                    state_n     = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    pending_n    = pending & ~(NREGS'(1) << out_idx);
                    beats_sent_n = beats_sent + (ADDR_W + 1)'(1);
                    out_valid_n  = 1'b0;
                    out_last_n   = 1'b0;
                    state_n      = out_last ? ST_DONE : ST_SCAN;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Abort wins over everything except the beat count of a same-cycle handshake.
        if (abort && state != ST_IDLE) begin
            state_n     = ST_IDLE;
            pending_n   = '0;
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
        end
    end

endmodule
